// File: rtl/piso_serializer_pkg.sv
// Shared types for the PISO serial transmitter.
// Holds the frame state encoding and divider limits.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } piso_state_t;

  localparam int PISO_MIN_CLK_DIV = 1;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word handshake into the PISO transmitter.
// master = user logic offering words, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/piso_serializer_timer.sv
// piso_bit_timer: bit-period divider for the serializer.
// Strobe marks the last clk of each serial bit period.
module piso_bit_timer
  import piso_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic strobe
);

  localparam int DIV = (CLK_DIV < PISO_MIN_CLK_DIV) ?
                       PISO_MIN_CLK_DIV : CLK_DIV;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q;

  assign strobe = run && (div_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (clear) begin
      div_q <= '0;
    end else if (run) begin
      div_q <= strobe ? '0 : div_q + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with valid/ready input.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  piso_serializer_if.slave bus,
  output logic ser_out,
  output logic ser_valid,
  output logic ser_strobe,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  piso_state_t      state;
  piso_state_t      state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             done_q;
  logic             accept;
  logic             last_bit;
  logic             frame_end;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign accept       = ena && bus.in_valid && (state == IDLE);
  assign busy         = (state != IDLE);
  assign bus.in_ready = (state == IDLE);
  assign ser_valid    = busy;
  assign done         = done_q && ena;
  assign last_bit     = (bit_cnt == CW'(1));
  assign frame_end    = ser_strobe && (state_nx == IDLE);

  piso_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (ena && busy),
    .clear (accept),
    .strobe(ser_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ser_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        ser_out = shreg[WIDTH-1];
        if (ser_strobe && last_bit)
`ifdef PISO_SERIALIZER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = IDLE;
`endif
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_out = par_q;
        if (ser_strobe) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // ena=0 freezes everything, including a pending done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else if (ena) begin
      done_q <= frame_end;
      if (accept) begin
        shreg   <= bus.in_data;
        bit_cnt <= CW'(WIDTH);
      end else if (ser_strobe && (state == SHIFT)) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^bus.in_data;
  end
`endif

endmodule
